// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle RV32M MUL/MULH/MULHSU/MULHU sequencer driving one shared external 32-bit adder
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i/req_ready_o       request handshake, op_a_i, op_b_i, mulop_i sampled on accept
//   rsp_valid_o/rsp_ready_i       response handshake, rsp_data_o held while stalled
//   busy_o                        high outside IDLE
//   add_a_o, add_b_o              operands to the external adder (carry-in tied 0)
//   add_s_i, add_c_i              adder sum and carry-out, same cycle
//   MUL_SEQ_SKIP_NEG_EN           when defined, negation states are skipped when not needed
module mul_seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [1:0]  mulop_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  input  logic [31:0] add_s_i,
  input  logic        add_c_i
);
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, MUL, NEG_LO, NEG_HI, DONE} state_e;
  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, phi_q, phi_d, plo_q, plo_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d, neg_q, neg_d, cy_q, cy_d;
  logic [4:0]  cnt_q, cnt_d;
  assign req_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign rsp_valid_o = state_q == DONE;
  assign rsp_data_o  = state_q != DONE ? '0 : op_q == 2'b00 ? plo_q : phi_q;
  // P_lo holds the multiplier from accept onward, so NEG_B negates it in place
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    neg_d   = neg_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    add_a_o = '0;
    add_b_o = '0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        a_d   = op_a_i;
        plo_d = op_b_i;
        phi_d = '0;
        cnt_d = '0;
        op_d  = mulop_i;
        sa_d  = op_a_i[31] & (mulop_i == 2'b01 || mulop_i == 2'b10);
        sb_d  = op_b_i[31] & (mulop_i == 2'b01);
        neg_d = sa_d ^ sb_d;
`ifdef MUL_SEQ_SKIP_NEG_EN
        state_d = sa_d ? NEG_A : sb_d ? NEG_B : MUL;
`else
        state_d = NEG_A;
`endif
      end
      NEG_A: begin
        add_a_o = ~a_q;
        add_b_o = 32'd1;
        a_d     = sa_q ? add_s_i : a_q;
`ifdef MUL_SEQ_SKIP_NEG_EN
        state_d = sb_q ? NEG_B : MUL;
`else
        state_d = NEG_B;
`endif
      end
      NEG_B: begin
        add_a_o = ~plo_q;
        add_b_o = 32'd1;
        plo_d   = sb_q ? add_s_i : plo_q;
        state_d = MUL;
      end
      MUL: begin
        add_a_o        = phi_q;
        add_b_o        = plo_q[0] ? a_q : '0;
        {phi_d, plo_d} = {add_c_i, add_s_i, plo_q[31:1]};
        cnt_d          = cnt_q + 5'd1;
`ifdef MUL_SEQ_SKIP_NEG_EN
        state_d = cnt_q == 5'd31 ? (neg_q ? NEG_LO : DONE) : MUL;
`else
        state_d = cnt_q == 5'd31 ? NEG_LO : MUL;
`endif
      end
      NEG_LO: begin
        add_a_o = ~plo_q;
        add_b_o = 32'd1;
        plo_d   = neg_q ? add_s_i : plo_q;
        cy_d    = neg_q & add_c_i;
        state_d = NEG_HI;
      end
      NEG_HI: begin
        add_a_o = ~phi_q;
        add_b_o = {31'b0, cy_q};
        phi_d   = neg_q ? add_s_i : phi_q;
        state_d = DONE;
      end
      DONE: state_d = rsp_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      neg_q   <= 1'b0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      neg_q   <= neg_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl with a behavioural ripple adder
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [1:0]  mulop = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] add_a, add_b, add_s;
  logic        add_c;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};
  mul_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_a_i(op_a), .op_b_i(op_b), .mulop_i(mulop), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .busy_o(busy),
    .add_a_o(add_a), .add_b_o(add_b), .add_s_i(add_s), .add_c_i(add_c)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = {{32{a[31] & (op == 2'b01 || op == 2'b10)}}, a};
    eb = {{32{b[31] & (op == 2'b01)}}, b};
    p = ea * eb;
    return op == 2'b00 ? p[31:0] : p[63:32];
  endfunction
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int sa, sb;
    sa = int'(a[31] & (op == 2'b01 || op == 2'b10));
    sb = int'(b[31] & (op == 2'b01));
`ifdef MUL_SEQ_SKIP_NEG_EN
    return 32 + sa + sb + 2 * (sa ^ sb);
`else
    return 36 + 0 * (sa + sb);
`endif
  endfunction
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_add_a"}, add_a, 0);
    check({tag, "_add_b"}, add_b, 0);
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input int stall, input bit noise);
    int n;
    logic [31:0] held;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    op_a = a;
    op_b = b;
    mulop = op;
    @(posedge clk);
    exp_q.push_back(model(a, b, op));
    #1;
    if (noise) begin
      op_a = ~a;
      op_b = a ^ 32'h5a5a5a5a;
      mulop = ~op;
    end else req_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", req_ready, 0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (noise && n == 4) req_valid = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    check("latency", n, exp_lat(a, b, op));
    if (!rsp_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    held = rsp_data;
    check("add_a_done", add_a, 0);
    check("add_b_done", add_b, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, held);
      check("hold_req_ready", req_ready, 0);
      check("hold_busy", busy, 1);
    end
    check("sb_nonempty", exp_q.size(), 1);
    if (exp_q.size() != 0) check("rsp_data", held, exp_q.pop_front());
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("idle_after_rsp", req_ready, 1);
  endtask
  initial begin
    int seen;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0, 0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 0);
    do_op(32'h80000000, 32'h80000000, 2'b01, 0, 0);
    do_op(32'hFFFFFFFF, 32'h00000001, 2'b01, 0, 1);
    do_op(32'h00000007, 32'hFFFFFFFD, 2'b00, 0, 0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 10, 0);
    do_op(32'h00000002, 32'h00000003, 2'b11, 0, 0);
    do_op(32'hFFFFFFFE, 32'h00000003, 2'b01, 0, 0);
    do_op(32'h00000000, 32'h80000000, 2'b01, 0, 0);
    do_op(32'h12345678, 32'h80000000, 2'b01, 0, 0);
    for (int i = 0; i < 12; i++) do_op($urandom, $urandom, 2'($urandom_range(0, 3)), i % 3, 0);
    @(negedge clk);
    req_valid = 1'b1;
    op_a = 32'hDEADBEEF;
    op_b = 32'h87654321;
    mulop = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_reset", seen, 0);
    check_reset_outputs("post_reset");
    do_op(32'd3, 32'd5, 2'b00, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
